// File: rtl/sample_reg_arbiter_if.sv
// Bundle between NREQ sample producers, the shared holding register and its consumer.
// The master modport is the arbiter side; slave is the producer/consumer environment.
interface sample_reg_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;
  logic                  busy;

  modport master (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_data, out_id, busy
  );

  modport slave (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/sample_reg_arbiter.sv
// Round-robin arbiter that loads one of NREQ sample words into a single holding register
// and presents it downstream with valid/ready; the winner gets a one-cycle registered grant.
module sample_reg_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input logic                  clk,
  input logic                  rst,
  sample_reg_arbiter_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q;
  logic             hold_off_q;

  logic [NREQ-1:0]  elig;
  logic             hi_found;
  logic [IDW-1:0]   hi_idx, lo_idx, win_idx;
  logic [WIDTH-1:0] win_data;
  logic             load;

  // The requester granted this cycle still holds req high; masking it stops a double win.
  assign elig = bus.req & ~gnt_q;

  // Lowest eligible index at or above ptr wins; otherwise the lowest eligible overall (wrap).
  always_comb begin : arbitrate
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign load = !hold_off_q && (|elig) && ((state_q == ST_IDLE) || bus.out_ready);

  always_comb begin : next_state
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    if (load) begin
      state_d = ST_HOLD;
      data_d  = win_data;
      id_d    = win_idx;
      gnt_d   = NREQ'(1) << win_idx;
      ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if ((state_q == ST_HOLD) && bus.out_ready) begin
      state_d = ST_IDLE;
    end
  end

  // hold_off_q blocks arbitration for one cycle after reset, so the first grant
  // lands on the second edge after rst falls.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      hold_off_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      busy_q     <= (state_d == ST_HOLD);
      hold_off_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sample_reg_arbiter.sv
// Directed bench for sample_reg_arbiter: a 4-requester instance checked through a word
// scoreboard, plus a 3-requester instance for pointer wrap-around.
module tb_sample_reg_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;
  logic [3:0] reassert = 4'b0000;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sample_reg_arbiter_if #(.WIDTH(16), .NREQ(4), .IDW(2)) bus4 ();
  sample_reg_arbiter_if #(.WIDTH(16), .NREQ(3), .IDW(2)) bus3 ();

  sample_reg_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  sample_reg_arbiter #(.WIDTH(16), .NREQ(3), .IDW(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [15:0] data);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    exp_t e;
    check("sb_nonempty", 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_id", 32'(bus4.out_id), 32'(e.id));
      check("sb_data", 32'(bus4.out_data), 32'(e.data));
    end
  endtask

  // One clock: score the word accepted at this edge, then act as the requesters.
  task automatic step();
    if (bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) sb_pop_check();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bus4.gnt[i] === 1'b1) begin
        if (reassert[i]) begin
          seq++;
          bus4.req_data[i*16 +: 16] = 16'hB000 + 16'(seq);
          push(i, 16'hB000 + 16'(seq));
        end else begin
          bus4.req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n;
    bus3.req       = '0;
    bus3.req_data  = '0;
    bus3.out_ready = 1'b0;

    // Reset held 3 cycles with every requester pending.
    rst            = 1'b1;
    bus4.req       = 4'b1111;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus4.req_data[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_gnt", 32'(bus4.gnt), 0);
      check("rst_valid", 32'(bus4.out_valid), 0);
      check("rst_data", 32'(bus4.out_data), 0);
    end
    check("rst_id", 32'(bus4.out_id), 0);
    check("rst_busy", 32'(bus4.busy), 0);
    rst = 1'b0;
    push(0, 16'hA000);
    step();
    check("post_rst1_gnt", 32'(bus4.gnt), 0);
    check("post_rst1_valid", 32'(bus4.out_valid), 0);
    step();
    check("first_gnt", 32'(bus4.gnt), 32'h1);
    check("first_valid", 32'(bus4.out_valid), 1);
    check("first_id", 32'(bus4.out_id), 0);
    check("first_data", 32'(bus4.out_data), 32'hA000);

    // Backpressure: requesters 1..3 pending while the consumer stalls.
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_gnt", 32'(bus4.gnt), 0);
      check("bp_id", 32'(bus4.out_id), 0);
      check("bp_data", 32'(bus4.out_data), 32'hA000);
      check("bp_busy", 32'(bus4.busy), 1);
    end
    push(1, 16'hA001);
    push(2, 16'hA002);
    push(3, 16'hA003);
    bus4.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("bp_burst_valid", 32'(bus4.out_valid), 1);
      check("bp_burst_gnt", 32'(bus4.gnt), 32'(4'b0001 << k));
    end
    step();
    check("bp_drained_valid", 32'(bus4.out_valid), 0);
    check("bp_drained_busy", 32'(bus4.busy), 0);

    // Single requester, then a one-cycle out_ready pulse.
    bus4.out_ready = 1'b0;
    bus4.req       = 4'b0100;
    bus4.req_data[2*16 +: 16] = 16'h1234;
    push(2, 16'h1234);
    step();
    check("single_valid", 32'(bus4.out_valid), 1);
    check("single_id", 32'(bus4.out_id), 2);
    check("single_data", 32'(bus4.out_data), 32'h1234);
    check("single_gnt", 32'(bus4.gnt), 32'h4);
    step();
    check("single_gnt_drop", 32'(bus4.gnt), 0);
    check("single_hold_data", 32'(bus4.out_data), 32'h1234);
    check("single_hold_valid", 32'(bus4.out_valid), 1);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check("single_release_valid", 32'(bus4.out_valid), 0);
    check("single_retain_id", 32'(bus4.out_id), 2);

    // Fairness: everyone re-requests after each grant; pointer sits at 3.
    for (int i = 0; i < 4; i++) bus4.req_data[i*16 +: 16] = 16'hD000 + 16'(i);
    push(3, 16'hD003);
    push(0, 16'hD000);
    push(1, 16'hD001);
    push(2, 16'hD002);
    reassert       = 4'b1111;
    bus4.req       = 4'b1111;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("rr_valid", 32'(bus4.out_valid), 1);
      check("rr_gnt_onehot", 32'($onehot(bus4.gnt)), 1);
    end
    reassert = 4'b0000;
    n = 0;
    while (bus4.out_valid === 1'b1 && n < 12) begin
      step();
      n++;
    end
    check("rr_drain_valid", 32'(bus4.out_valid), 0);
    check("rr_sb_empty", 32'(sb_q.size()), 0);

    // Reset while holding id 1; pointer must return to 0 (req 1010 then picks 1, not 3).
    bus4.out_ready = 1'b0;
    bus4.req       = 4'b0010;
    bus4.req_data[1*16 +: 16] = 16'hC0C1;
    push(1, 16'hC0C1);
    step();
    check("mid_hold_id", 32'(bus4.out_id), 1);
    check("mid_hold_valid", 32'(bus4.out_valid), 1);
    bus4.req = 4'b1010;
    bus4.req_data[1*16 +: 16] = 16'hC001;
    bus4.req_data[3*16 +: 16] = 16'hC003;
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(bus4.out_valid), 0);
    check("mid_rst_gnt", 32'(bus4.gnt), 0);
    check("mid_rst_data", 32'(bus4.out_data), 0);
    check("mid_rst_busy", 32'(bus4.busy), 0);
    sb_q.delete();
    push(1, 16'hC001);
    push(3, 16'hC003);
    rst = 1'b0;
    step();
    check("mid_post_rst_gnt", 32'(bus4.gnt), 0);
    step();
    check("mid_regrant_gnt", 32'(bus4.gnt), 32'h2);
    check("mid_regrant_id", 32'(bus4.out_id), 1);
    check("mid_regrant_data", 32'(bus4.out_data), 32'hC001);
    bus4.out_ready = 1'b1;
    step();
    check("mid_next_id", 32'(bus4.out_id), 3);
    step();
    check("mid_end_valid", 32'(bus4.out_valid), 0);
    check("mid_sb_empty", 32'(sb_q.size()), 0);
    bus4.out_ready = 1'b0;

    // Pointer wrap on the 3-requester instance: after id 2, req 101 must pick id 0.
    bus3.req = 3'b100;
    bus3.req_data[2*16 +: 16] = 16'h0333;
    step();
    check("wrap_gnt2", 32'(bus3.gnt), 32'h4);
    check("wrap_id2", 32'(bus3.out_id), 2);
    check("wrap_data2", 32'(bus3.out_data), 32'h0333);
    bus3.req = 3'b101;
    bus3.req_data[0*16 +: 16] = 16'h0300;
    bus3.req_data[2*16 +: 16] = 16'h0334;
    step();
    check("wrap_stall_gnt", 32'(bus3.gnt), 0);
    check("wrap_stall_id", 32'(bus3.out_id), 2);
    bus3.out_ready = 1'b1;
    step();
    check("wrap_id0", 32'(bus3.out_id), 0);
    check("wrap_gnt0", 32'(bus3.gnt), 32'h1);
    check("wrap_data0", 32'(bus3.out_data), 32'h0300);
    bus3.req = 3'b100;
    step();
    check("wrap_back_id2", 32'(bus3.out_id), 2);
    check("wrap_back_data", 32'(bus3.out_data), 32'h0334);
    bus3.req = 3'b000;
    step();
    check("wrap_end_valid", 32'(bus3.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
